// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle main controller and the datapath.
// The controller drives the master side; the datapath/ALU side uses slave.
interface mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       op;
   logic [5:0]       funct;
   logic             alu_eq;
   logic             PCWr;
   logic             IRWr;
   logic             RegWr;
   logic             MemWr;
   logic [2:0]       ALUctr;
   logic             ALUSrcB;
   logic [1:0]       ExtOp;
   logic [1:0]       RegDst;
   logic [1:0]       MemtoReg;
   logic [1:0]       NPCOp;
   logic [2:0]       state;
   logic [CNT_W-1:0] instr_cnt;

   modport master (
      input  op, funct, alu_eq,
      output PCWr, IRWr, RegWr, MemWr, ALUctr, ALUSrcB, ExtOp,
             RegDst, MemtoReg, NPCOp, state, instr_cnt
   );

   modport slave (
      output op, funct, alu_eq,
      input  PCWr, IRWr, RegWr, MemWr, ALUctr, ALUSrcB, ExtOp,
             RegDst, MemtoReg, NPCOp, state, instr_cnt
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: walks each instruction through FETCH/DECODE/
// EXEC/MEM/WB, drives datapath controls and counts retired instructions.
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic      clk,
   input  logic      reset,
   mc_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_JR    = 6'h08;

   state_e           r_state;
   state_e           w_nextState;
   logic [CNT_W-1:0] r_instrCnt;
   logic             w_retire;

   logic w_isAddu, w_isSubu, w_isJr, w_isOri, w_isLw, w_isSw;
   logic w_isBeq, w_isLui, w_isJ, w_isJal, w_isRtype, w_needsExec;

   logic       w_pcWr, w_irWr, w_regWr, w_memWr;
   logic [2:0] w_aluCtr;
   logic       w_aluSrcB;
   logic [1:0] w_extOp, w_regDst, w_memtoReg, w_npcOp;

   always_comb begin
      w_isAddu    = (bus.op == OP_RTYPE) && (bus.funct == FN_ADDU);
      w_isSubu    = (bus.op == OP_RTYPE) && (bus.funct == FN_SUBU);
      w_isJr      = (bus.op == OP_RTYPE) && (bus.funct == FN_JR);
      w_isOri     = (bus.op == OP_ORI);
      w_isLw      = (bus.op == OP_LW);
      w_isSw      = (bus.op == OP_SW);
      w_isBeq     = (bus.op == OP_BEQ);
      w_isLui     = (bus.op == OP_LUI);
      w_isJ       = (bus.op == OP_J);
      w_isJal     = (bus.op == OP_JAL);
      w_isRtype   = w_isAddu || w_isSubu;
      w_needsExec = w_isRtype || w_isOri || w_isLw || w_isSw || w_isBeq || w_isLui;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Reset takes priority so an abandoned instruction never counts as retired.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_instrCnt <= '0;
      end else if (w_retire) begin
         r_instrCnt <= r_instrCnt + 1'b1;
      end
   end

   always_comb begin
      w_nextState = FETCH;
      w_retire    = 1'b0;
      case (r_state)
         FETCH: begin
            w_nextState = DECODE;
         end
         DECODE: begin
            if (w_needsExec) begin
               w_nextState = EXEC;
            end else begin
               w_retire = 1'b1;
            end
         end
         EXEC: begin
            if (w_isBeq) begin
               w_retire = 1'b1;
            end else if (w_isLw || w_isSw) begin
               w_nextState = MEM;
            end else begin
               w_nextState = WB;
            end
         end
         MEM: begin
            if (w_isSw) begin
               w_retire = 1'b1;
            end else begin
               w_nextState = WB;
            end
         end
         WB: begin
            w_retire = 1'b1;
         end
         default: begin
            w_nextState = FETCH;
         end
      endcase
   end

   always_comb begin
      w_pcWr     = 1'b0;
      w_irWr     = 1'b0;
      w_regWr    = 1'b0;
      w_memWr    = 1'b0;
      w_aluCtr   = 3'd0;
      w_aluSrcB  = 1'b0;
      w_extOp    = 2'd0;
      w_regDst   = 2'd0;
      w_memtoReg = 2'd0;
      w_npcOp    = 2'd0;
      case (r_state)
         FETCH: begin
            w_irWr = 1'b1;
            w_pcWr = 1'b1;
         end
         DECODE: begin
            if (w_isJal) begin
               w_pcWr     = 1'b1;
               w_npcOp    = 2'd2;
               w_regWr    = 1'b1;
               w_regDst   = 2'd2;
               w_memtoReg = 2'd2;
            end else if (w_isJ) begin
               w_pcWr  = 1'b1;
               w_npcOp = 2'd2;
            end else if (w_isJr) begin
               w_pcWr  = 1'b1;
               w_npcOp = 2'd3;
            end
         end
         EXEC: begin
            if (w_isSubu) begin
               w_aluCtr = 3'd1;
            end else if (w_isOri) begin
               w_aluCtr  = 3'd2;
               w_aluSrcB = 1'b1;
            end else if (w_isLui) begin
               w_aluSrcB = 1'b1;
               w_extOp   = 2'd2;
            end else if (w_isLw || w_isSw) begin
               w_aluSrcB = 1'b1;
               w_extOp   = 2'd1;
            end else if (w_isBeq) begin
               // Branch decision comes straight from the ALU in this cycle.
               w_aluCtr = 3'd3;
               w_extOp  = 2'd1;
               w_pcWr   = bus.alu_eq;
               w_npcOp  = 2'd1;
            end
         end
         MEM: begin
            w_memWr = w_isSw;
         end
         WB: begin
            w_regWr    = 1'b1;
            w_memtoReg = w_isLw ? 2'd1 : 2'd0;
            w_regDst   = w_isRtype ? 2'd1 : 2'd0;
         end
         default: begin
            w_pcWr = 1'b0;
         end
      endcase
   end

   assign bus.PCWr      = w_pcWr  & reset;
   assign bus.IRWr      = w_irWr  & reset;
   assign bus.RegWr     = w_regWr & reset;
   assign bus.MemWr     = w_memWr & reset;
   assign bus.ALUctr    = w_aluCtr;
   assign bus.ALUSrcB   = w_aluSrcB;
   assign bus.ExtOp     = w_extOp;
   assign bus.RegDst    = w_regDst;
   assign bus.MemtoReg  = w_memtoReg;
   assign bus.NPCOp     = w_npcOp;
   assign bus.state     = r_state;
   assign bus.instr_cnt = r_instrCnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed table of instructions, reset corner
// cases, and random instruction streams against a per-instruction model.
module tb_mc_ctrl;

   logic clk;
   logic reset;

   mc_ctrl_if #(.CNT_W(32)) bus ();

   mc_ctrl #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LW, K_SW, K_BEQ,
                     K_LUI, K_J, K_JAL, K_NOP} kind_e;

   typedef struct {
      logic [5:0] op;
      logic [5:0] funct;
      bit         eq;
      int         lat;
      int         nPc;
      int         nReg;
      int         nMem;
      int         alu;
      int         srcB;
      int         ext;
      int         regDst;
      int         memtoReg;
      int         npc;
   } vec_t;

   int          nVectors = 0;
   int          nMiscompares = 0;
   logic [31:0] expCnt = 0;
   vec_t        tbl[$];

   task automatic checkOutput(input string name, input longint act, input longint exp);
      nVectors++;
      if (act != exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic kind_e classify(logic [5:0] op, logic [5:0] funct);
      case (op)
         6'h00: begin
            if (funct == 6'h21) return K_ADDU;
            if (funct == 6'h23) return K_SUBU;
            if (funct == 6'h08) return K_JR;
            return K_NOP;
         end
         6'h0d: return K_ORI;
         6'h23: return K_LW;
         6'h2b: return K_SW;
         6'h04: return K_BEQ;
         6'h0f: return K_LUI;
         6'h02: return K_J;
         6'h03: return K_JAL;
         default: return K_NOP;
      endcase
   endfunction

   // Expected control word {state, PCWr, IRWr, RegWr, MemWr, ALUctr, ALUSrcB,
   // ExtOp, RegDst, MemtoReg, NPCOp} for an instruction kind in a given state.
   function automatic logic [18:0] expectCycle(kind_e k, int st, bit eq);
      logic pcw = 0, irw = 0, rw = 0, mw = 0;
      int alu = 0, srcb = 0, ext = 0, rd = 0, m2r = 0, npc = 0;
      case (st)
         0: begin irw = 1; pcw = 1; end
         1: begin
            if (k == K_JAL) begin pcw = 1; npc = 2; rw = 1; rd = 2; m2r = 2; end
            if (k == K_J)   begin pcw = 1; npc = 2; end
            if (k == K_JR)  begin pcw = 1; npc = 3; end
         end
         2: begin
            if (k == K_SUBU) alu = 1;
            if (k == K_ORI) begin alu = 2; srcb = 1; end
            if (k == K_LUI) begin srcb = 1; ext = 2; end
            if (k == K_LW || k == K_SW) begin srcb = 1; ext = 1; end
            if (k == K_BEQ) begin alu = 3; ext = 1; pcw = eq; npc = 1; end
         end
         3: mw = (k == K_SW);
         4: begin
            rw  = 1;
            m2r = (k == K_LW) ? 1 : 0;
            rd  = (k == K_ADDU || k == K_SUBU) ? 1 : 0;
         end
         default: ;
      endcase
      return {st[2:0], pcw, irw, rw, mw, alu[2:0], srcb[0], ext[1:0],
              rd[1:0], m2r[1:0], npc[1:0]};
   endfunction

   function automatic logic [18:0] observed();
      return {bus.state, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.ALUctr,
              bus.ALUSrcB, bus.ExtOp, bus.RegDst, bus.MemtoReg, bus.NPCOp};
   endfunction

   // Starts just after a rising edge with the controller in FETCH.
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct);
      kind_e k;
      int    seq[$];
      bit    eq;
      k = classify(op, funct);
      seq = '{0, 1};
      case (k)
         K_BEQ:                        seq.push_back(2);
         K_SW:                         begin seq.push_back(2); seq.push_back(3); end
         K_LW:                         begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
         K_ADDU, K_SUBU, K_ORI, K_LUI: begin seq.push_back(2); seq.push_back(4); end
         default: ;
      endcase
      bus.op    = op;
      bus.funct = funct;
      foreach (seq[i]) begin
         eq = 1'($urandom_range(0, 1));
         bus.alu_eq = eq;
         @(negedge clk);
         checkOutput($sformatf("cycle op=%02h fn=%02h st=%0d", op, funct, seq[i]),
                     observed(), expectCycle(k, seq[i], eq));
         @(posedge clk);
         #1;
      end
      expCnt = expCnt + 1;
      checkOutput("instr_cnt", bus.instr_cnt, expCnt);
   endtask

   function automatic vec_t mk(logic [5:0] op, logic [5:0] fn, bit eq, int lat,
                               int nPc, int nReg, int nMem, int alu, int srcB,
                               int ext, int regDst, int memtoReg, int npc);
      vec_t v;
      v.op = op; v.funct = fn; v.eq = eq; v.lat = lat; v.nPc = nPc;
      v.nReg = nReg; v.nMem = nMem; v.alu = alu; v.srcB = srcB; v.ext = ext;
      v.regDst = regDst; v.memtoReg = memtoReg; v.npc = npc;
      return v;
   endfunction

   task automatic runVector(input int idx, input vec_t v);
      int lat = 0, nPc = 0, nReg = 0, nMem = 0;
      int alu = 0, srcB = 0, ext = 0, rd = 0, m2r = 0, npc = 0;
      bus.op     = v.op;
      bus.funct  = v.funct;
      bus.alu_eq = v.eq;
      do begin
         @(negedge clk);
         lat++;
         if (bus.PCWr) nPc++;
         if (bus.RegWr) begin nReg++; rd = bus.RegDst; m2r = bus.MemtoReg; end
         if (bus.MemWr) nMem++;
         if (bus.PCWr && bus.state != 3'd0) npc = bus.NPCOp;
         if (bus.state == 3'd2) begin alu = bus.ALUctr; srcB = bus.ALUSrcB; ext = bus.ExtOp; end
         @(posedge clk);
         #1;
      end while (bus.state != 3'd0 && lat < 10);
      checkOutput($sformatf("v%0d latency", idx), lat, v.lat);
      checkOutput($sformatf("v%0d PCWr count", idx), nPc, v.nPc);
      checkOutput($sformatf("v%0d RegWr count", idx), nReg, v.nReg);
      checkOutput($sformatf("v%0d MemWr count", idx), nMem, v.nMem);
      if (v.lat >= 3) begin
         checkOutput($sformatf("v%0d EXEC ALUctr", idx), alu, v.alu);
         checkOutput($sformatf("v%0d EXEC ALUSrcB", idx), srcB, v.srcB);
         checkOutput($sformatf("v%0d EXEC ExtOp", idx), ext, v.ext);
      end
      if (v.nReg > 0) begin
         checkOutput($sformatf("v%0d RegDst", idx), rd, v.regDst);
         checkOutput($sformatf("v%0d MemtoReg", idx), m2r, v.memtoReg);
      end
      if (v.nPc > 1) checkOutput($sformatf("v%0d NPCOp", idx), npc, v.npc);
      expCnt = expCnt + 1;
      checkOutput($sformatf("v%0d instr_cnt", idx), bus.instr_cnt, expCnt);
   endtask

   initial begin
      logic [5:0] rop, rfn;
      int         pick;

      //           op     fn    eq lat pc rg mm alu sB ext rd m2r npc
      tbl.push_back(mk(6'h00, 6'h21, 0, 4, 1, 1, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(6'h00, 6'h23, 0, 4, 1, 1, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(6'h0d, 6'h00, 0, 4, 1, 1, 0, 2, 1, 0, 0, 0, 0));
      tbl.push_back(mk(6'h0f, 6'h00, 0, 4, 1, 1, 0, 0, 1, 2, 0, 0, 0));
      tbl.push_back(mk(6'h2b, 6'h00, 0, 4, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(6'h23, 6'h00, 0, 5, 1, 1, 0, 0, 1, 1, 0, 1, 0));
      tbl.push_back(mk(6'h04, 6'h00, 1, 3, 2, 0, 0, 3, 0, 1, 0, 0, 1));
      tbl.push_back(mk(6'h04, 6'h00, 0, 3, 1, 0, 0, 3, 0, 1, 0, 0, 0));
      tbl.push_back(mk(6'h03, 6'h00, 0, 2, 2, 1, 0, 0, 0, 0, 2, 2, 2));
      tbl.push_back(mk(6'h02, 6'h00, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 2));
      tbl.push_back(mk(6'h00, 6'h08, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 3));
      tbl.push_back(mk(6'h3f, 6'h00, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(6'h00, 6'h00, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));

      reset      = 1'b0;
      bus.op     = 6'h23;
      bus.funct  = 6'h00;
      bus.alu_eq = 1'b0;

      // Held reset: FETCH, no writes, counter cleared, even with lw on op.
      repeat (3) begin
         @(negedge clk);
         checkOutput("reset state", bus.state, 0);
         checkOutput("reset write enables",
                     {bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr}, 0);
         checkOutput("reset instr_cnt", bus.instr_cnt, 0);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      applyStimulus(6'h23, 6'h00);

      foreach (tbl[i]) runVector(i, tbl[i]);

      // Unknown opcode, then reset dropped during MEM of sw.
      applyStimulus(6'h3f, 6'h15);
      bus.op = 6'h2b;
      bus.funct = 6'h00;
      repeat (3) begin
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      @(negedge clk);
      checkOutput("sw reset in MEM state", bus.state, 3);
      checkOutput("sw reset MemWr", bus.MemWr, 0);
      @(posedge clk);
      #1;
      checkOutput("sw reset next state", bus.state, 0);
      expCnt = 0;
      checkOutput("sw reset instr_cnt", bus.instr_cnt, expCnt);
      reset = 1'b1;

      for (int n = 0; n < 200; n++) begin
         pick = $urandom_range(0, 11);
         rfn  = 6'($urandom);
         case (pick)
            0: begin rop = 6'h00; rfn = 6'h21; end
            1: begin rop = 6'h00; rfn = 6'h23; end
            2: begin rop = 6'h00; rfn = 6'h08; end
            3: rop = 6'h0d;
            4: rop = 6'h23;
            5: rop = 6'h2b;
            6: rop = 6'h04;
            7: rop = 6'h0f;
            8: rop = 6'h02;
            9: rop = 6'h03;
            10: rop = 6'h00;
            default: rop = 6'($urandom);
         endcase
         applyStimulus(rop, rfn);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller for the non-layered CPU datapath; the producer end of the ALU control interface.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- In each state, drives ALUctr, mux selects and write enables to PC, IR, GRF and DM.
- Counts retired instructions for bench and debug.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_cnt

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous reset, active-low
op  input  6  IR[31:26], valid from DECODE onward
funct  input  6  IR[5:0]
alu_eq  input  1  ALU result bit 0 in EXEC of beq (ALUctr=3)
PCWr  output  1  PC write enable
IRWr  output  1  IR write enable
RegWr  output  1  GRF write enable
MemWr  output  1  DM write enable
ALUctr  output  3  0 add, 1 sub, 2 or, 3 eq; others are reserved
ALUSrcB  output  1  0 = GRF[rt], 1 = extended immediate
ExtOp  output  2  0 zero-ext, 1 sign-ext, 2 imm<<16
RegDst  output  2  0 rt, 1 rd, 2 $31
MemtoReg  output  2  0 ALU out, 1 DM data, 2 PC+4
NPCOp  output  2  0 PC+4, 1 branch, 2 j/jal target, 3 GRF[rs]
state  output  3  current state, for debug
instr_cnt  output  CNT_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Values 5–7 are illegal and go to FETCH on the next edge.
- Reset, when reset=0 at a rising edge:
  - state=FETCH, instr_cnt=0.
  - While reset=0, PCWr, IRWr, RegWr and MemWr are forced to 0 regardless of state.
  - Reset mid-instruction abandons the instruction; no counter increment.
- Recognised instructions:
  - addu: op 0, funct 0x21
  - subu: op 0, funct 0x23
  - jr: op 0, funct 0x08
  - ori 0x0d, lw 0x23, sw 0x2b, beq 0x04, lui 0x0f, j 0x02, jal 0x03
  - Any other op/funct is treated as nop.
- FETCH:
  - IRWr=1, PCWr=1, NPCOp=0.
  - Next state is DECODE.
- DECODE:
  - jal: PCWr=1, NPCOp=2, RegWr=1, RegDst=2, MemtoReg=2. Retires; next state FETCH.
  - j: PCWr=1, NPCOp=2. Retires; next state FETCH.
  - jr: PCWr=1, NPCOp=3. Retires; next state FETCH.
  - nop or unrecognised: no writes. Retires; next state FETCH.
  - All others: next state EXEC.
- EXEC (ALUctr and ALUSrcB held stable for the whole state):
  - addu: ALUctr=0, ALUSrcB=0.
  - subu: ALUctr=1, ALUSrcB=0.
  - ori: ALUctr=2, ALUSrcB=1, ExtOp=0.
  - lui: ALUctr=0, ALUSrcB=1, ExtOp=2 (rs=$0, so the result is imm<<16).
  - lw/sw: ALUctr=0, ALUSrcB=1, ExtOp=1.
  - beq: ALUctr=3, ALUSrcB=0, ExtOp=1. PCWr=alu_eq and NPCOp=1; this is the only Mealy output. Retires; next state FETCH.
  - lw, sw go to MEM; R-type, ori and lui go to WB.
- MEM:
  - sw: MemWr=1. Retires; next state FETCH.
  - lw: no writes; next state WB.
- WB:
  - RegWr=1. MemtoReg=1 for lw, else 0. RegDst=1 for R-type, else 0.
  - Retires; next state FETCH.
- Idle output values: outputs not listed for a state are 0, and at most one write enable among RegWr/MemWr is asserted.
- Latency in cycles, FETCH to return to FETCH:
  - j, jal, jr, nop: 2
  - beq: 3
  - R-type, ori, lui, sw: 4
  - lw: 5
- instr_cnt:
  - Increments by 1 at the clock edge leaving any retiring state.
  - Wraps from 2^CNT_W−1 to 0.

Test Plan:
- Reset held low 3 cycles while op=0x23 -> state=0, all write enables 0, instr_cnt=0; after release, the first cycle shows IRWr=1 and PCWr=1.
- lw (op 0x23) -> state sequence 0,1,2,3,4,0; in EXEC, ALUctr=0, ALUSrcB=1, ExtOp=1; in WB, RegWr=1 and MemtoReg=1; instr_cnt +1 after 5 cycles.
- beq with alu_eq=1, then alu_eq=0 -> EXEC shows ALUctr=3; PCWr=1/NPCOp=1 for the first, PCWr=0 for the second; each takes 3 cycles.
- jal (op 0x03) -> in DECODE, PCWr=1, NPCOp=2, RegWr=1, RegDst=2, MemtoReg=2; back to FETCH after 2 cycles.
- Sequence addu, subu, ori, lui, sw -> ALUctr 0,1,2,0,0 in EXEC; MemWr=1 only in MEM of sw; instr_cnt=5.
- Unknown op 0x3f, plus reset=0 asserted during MEM of sw -> op 0x3f retires in 2 cycles with no writes; the reset gives no MemWr pulse, and the next state is FETCH.
